acc_block_dump: RTL
===================

// Module: acc_block_dump
// PURPOSE
//   Integrate-and-dump stage directly downstream of the running accumulator.
//   Consumes a valid/ready sample stream, sums exactly N samples per block,
//   and hands each completed block sum to the next stage through a 1-deep
//   valid/ready output register.
//   The internal accumulator clears every N samples with no bubble cycle.
//   Sums are sized so they can never wrap.
// PARAMETERS
//   DW  8              input sample width (unsigned)
//   N   4              samples per block; must be >= 2 (elaboration error otherwise)
//   OW  DW+$clog2(N)   output sum width; derived, not overridden
// PORTS
//   clk        in   1    clock; all logic is rising-edge
//   rst        in   1    reset; synchronous, active-high
//   in_valid   in   1    upstream sample valid
//   in_ready   out  1    stage can accept a sample this cycle
//   in_data    in   DW   sample; unsigned, zero-extended to OW
//   out_valid  out  1    block sum available
//   out_ready  in   1    downstream accepts the sum
//   out_sum    out  OW   sum of the last completed block of N samples
//   out_avg    out  DW   present only with ACC_BLOCK_DUMP_AVG_EN
// BEHAVIOUR
//   Definitions
//   - Accept = in_valid && in_ready.
//   - Pop = out_valid && out_ready.
//   Reset (rst=1 at a clk edge; dominates all other inputs)
//   - acc <= 0, cnt <= 0, out_valid <= 0, out_sum <= 0 (out_avg <= 0).
//   - Any partial block is discarded.
//   Counting
//   - cnt runs 0..N-1 and counts accepted samples within the current block.
//   Datapath
//   - Width OW throughout.
//   - N*(2^DW-1) always fits in OW, so no saturation or wrap logic exists.
//   Accept with cnt < N-1
//   - acc <= acc + in_data; cnt <= cnt + 1.
//   Accept with cnt == N-1 (block complete)
//   - out_sum <= acc + in_data; out_valid <= 1.
//   - acc <= 0; cnt <= 0, at the same edge.
//   - Latency: out_valid is high the cycle after the Nth accept.
//   in_ready (combinational)
//   - in_ready = (cnt != N-1) || !out_valid || out_ready.
//   - The stage stalls only when the completing sample would overwrite an
//     unconsumed sum.
//   - in_ready has no dependence on in_valid.
//   Output handshake
//   - Pop without a new block completing: out_valid <= 0.
//   - Pop and block completion in the same cycle: out_valid stays 1 and
//     out_sum takes the new block sum.
//   - Full throughput: one sample per cycle, indefinitely, while out_ready=1.
//   Stability
//   - While out_valid && !out_ready, out_sum and out_avg hold their values.
//   - out_valid never drops without a pop.
//   Idle cycles
//   - in_valid=0 changes no state other than pop effects.
// CONFIGURATION
//   Macro ACC_BLOCK_DUMP_AVG_EN
//   Defined
//   - Adds port out_avg[DW-1:0].
//   - out_avg = (acc + in_data) >> $clog2(N), registered together with out_sum.
//   - Truncating divide.
//   - N must be a power of 2 (elaboration error otherwise).
//   Undefined
//   - No out_avg port and no divide logic; N may be any value >= 2.
// TESTING (DW=8, N=4)
//   1. rst 2 cycles; samples 1,2,3,4 back-to-back, out_ready=1
//      -> out_valid for 1 cycle, exactly 1 cycle after the 4th accept;
//         out_sum=10.
//   2. Four samples of 255
//      -> out_sum=1020 (OW=10); no wrap.
//   3. out_ready=0; stream 1..8 continuously
//      -> 7 accepted; in_ready=0 with cnt==3;
//         out_sum holds 10 until out_ready=1.
//      Then out_ready=1
//      -> 8 accepted that cycle; out_valid stays 1; out_sum=26 next cycle.
//   4. out_ready=1 in the same cycle as the Nth sample of the next block
//      -> accepted; no out_valid gap; out_sum updates.
//   5. rst asserted after 2 samples (5,5); then samples 1,1,1,1
//      -> out_sum=4, not 14; out_valid=0 during and directly after reset.
//   6. ACC_BLOCK_DUMP_AVG_EN: samples 1,2,3,4 -> out_avg=2;
//      samples 255 x4 -> out_avg=255.

Source files
------------

// File: rtl/acc_block_dump_if.sv
// Sample-in / block-sum-out handshake bundle for acc_block_dump.
// out_avg exists only when ACC_BLOCK_DUMP_AVG_EN is defined.
interface acc_block_dump_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned N  = 4
);
   localparam int unsigned OW = DW + $clog2(N);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_sum;
`ifdef ACC_BLOCK_DUMP_AVG_EN
   logic [DW-1:0] out_avg;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_avg
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_avg
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum
   );
`endif
endinterface

// File: rtl/acc_block_dump.sv
// Integrate-and-dump: sums N accepted samples per block into a 1-deep output register.
// Defining ACC_BLOCK_DUMP_AVG_EN adds out_avg = block sum >> log2(N) (N must be a power of 2).
module acc_block_dump #(
   parameter int unsigned DW = 8,
   parameter int unsigned N  = 4
) (
   input logic             clk,
   input logic             rst,
   acc_block_dump_if.slave bus
);
   localparam int unsigned   CW      = $clog2(N);
   localparam int unsigned   OW      = DW + CW;
   localparam logic [CW-1:0] CntLast = CW'(N - 1);

   if (N < 2) begin : g_n_min
      $error("acc_block_dump: N must be >= 2");
   end

   logic [OW-1:0] acc_q;
   logic [OW-1:0] out_sum_q;
   logic [OW-1:0] blk_sum;
   logic [CW-1:0] cnt_q;
   logic          out_valid_q;
   logic          last;
   logic          accept;
   logic          pop;

   assign last    = (cnt_q == CntLast);
   assign blk_sum = acc_q + OW'(bus.in_data);

   // Stall only when the completing sample would overwrite an unconsumed sum.
   assign bus.in_ready = !last || !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign pop          = out_valid_q && bus.out_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;

`ifdef ACC_BLOCK_DUMP_AVG_EN
   if (N != (1 << CW)) begin : g_n_pow2
      $error("acc_block_dump: N must be a power of 2 when out_avg is enabled");
   end

   logic [DW-1:0] out_avg_q;
   assign bus.out_avg = out_avg_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
`ifdef ACC_BLOCK_DUMP_AVG_EN
         out_avg_q   <= '0;
`endif
      end else begin
         if (pop) begin
            out_valid_q <= 1'b0;
         end
         // A completing block overrides the pop clear, so there is no valid gap.
         if (accept) begin
            if (last) begin
               acc_q       <= '0;
               cnt_q       <= '0;
               out_sum_q   <= blk_sum;
               out_valid_q <= 1'b1;
`ifdef ACC_BLOCK_DUMP_AVG_EN
               out_avg_q   <= DW'(blk_sum >> CW);
`endif
            end else begin
               acc_q <= blk_sum;
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end
endmodule
